// File: rtl/writeback_stage_unit.sv
// MEM/WB pipeline register and result selection for the writeback stage.
// Optional build macro: WB_X0_WRITE_GUARD_EN keeps register-file writes to x0 from being issued.
module writeback_stage_unit #(
    parameter int DPW = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           regwriteM,
    input  logic           resultsrcM,
    input  logic [DPW-1:0] aluresultM,
    input  logic [DPW-1:0] ReadDataM,
    input  logic [4:0]     RdM,
    output logic           regwriteW,
    output logic           resultsrcW,
    output logic [DPW-1:0] resultW,
    output logic [4:0]     RdW
);

    logic           regwriteR;
    logic           resultsrcR;
    logic [DPW-1:0] aluresultR;
    logic [DPW-1:0] readDataR;
    logic [4:0]     rdR;
    logic           regwriteNextS;
    logic [DPW-1:0] resultS;

    // Write-enable value to be captured on the next edge.
    always_comb begin
        regwriteNextS = 1'b0;
`ifdef WB_X0_WRITE_GUARD_EN
        if (RdM != 5'd0) begin
            regwriteNextS = regwriteM;
        end else begin
            regwriteNextS = 1'b0;
        end
`else
        regwriteNextS = regwriteM;
`endif
    end

    // MEM/WB pipeline register; loads every cycle, no stall or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwriteR  <= 1'b0;
            resultsrcR <= 1'b0;
            aluresultR <= {DPW{1'b0}};
            readDataR  <= {DPW{1'b0}};
            rdR        <= 5'd0;
        end else begin
            regwriteR  <= regwriteNextS;
            resultsrcR <= resultsrcM;
            aluresultR <= aluresultM;
            readDataR  <= ReadDataM;
            rdR        <= RdM;
        end
    end

    // Result mux built only from registered values, so M-stage changes never leak through.
    always_comb begin
        resultS = {DPW{1'b0}};
        if (resultsrcR) begin
            resultS = readDataR;
        end else begin
            resultS = aluresultR;
        end
    end

    assign regwriteW  = regwriteR;
    assign resultsrcW = resultsrcR;
    assign RdW        = rdR;
    assign resultW    = resultS;

endmodule

// File: tb/tb_writeback_stage_unit.sv
// Directed self-checking bench for writeback_stage_unit.
module tb_writeback_stage_unit;

    logic        clk;
    logic        rst_n;
    logic        regwriteM;
    logic        resultsrcM;
    logic [31:0] aluresultM;
    logic [31:0] ReadDataM;
    logic [4:0]  RdM;
    logic        regwriteW;
    logic        resultsrcW;
    logic [31:0] resultW;
    logic [4:0]  RdW;

    int checks;
    int errors;

    writeback_stage_unit #(.DPW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .regwriteM  (regwriteM),
        .resultsrcM (resultsrcM),
        .aluresultM (aluresultM),
        .ReadDataM  (ReadDataM),
        .RdM        (RdM),
        .regwriteW  (regwriteW),
        .resultsrcW (resultsrcW),
        .resultW    (resultW),
        .RdW        (RdW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        regwriteM  = 1'b1;
        resultsrcM = 1'b1;
        aluresultM = 32'hDEAD_BEEF;
        ReadDataM  = 32'hCAFE_F00D;
        RdM        = 5'd17;
        tick();
        tick();
        checks++; if (regwriteW !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %0h want 0", regwriteW); end
        checks++; if (resultsrcW !== 1'b0) begin errors++; $display("FAIL reset_resultsrc got %0h want 0", resultsrcW); end
        checks++; if (RdW !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", RdW); end
        checks++; if (resultW !== 32'h0) begin errors++; $display("FAIL reset_result got %08h want 0", resultW); end
        @(negedge clk);
        rst_n      = 1'b1;
        resultsrcM = 1'b0;
        aluresultM = 32'h1234_5678;
        RdM        = 5'd3;
        tick();
        checks++; if (resultW !== 32'h1234_5678) begin errors++; $display("FAIL release_result got %08h want 12345678", resultW); end
        checks++; if (RdW !== 5'd3) begin errors++; $display("FAIL release_rd got %0d want 3", RdW); end
        checks++; if (regwriteW !== 1'b1) begin errors++; $display("FAIL release_regwrite got %0h want 1", regwriteW); end
    endtask

    task automatic test_load_select();
        @(negedge clk);
        resultsrcM = 1'b1;
        aluresultM = 32'd5;
        ReadDataM  = 32'd2;
        regwriteM  = 1'b1;
        RdM        = 5'd7;
        tick();
        checks++; if (resultW !== 32'd2) begin errors++; $display("FAIL load_result got %0d want 2", resultW); end
        checks++; if (resultsrcW !== 1'b1) begin errors++; $display("FAIL load_resultsrc got %0h want 1", resultsrcW); end
        checks++; if (regwriteW !== 1'b1) begin errors++; $display("FAIL load_regwrite got %0h want 1", regwriteW); end
        checks++; if (RdW !== 5'd7) begin errors++; $display("FAIL load_rd got %0d want 7", RdW); end
    endtask

    task automatic test_alu_hold();
        @(negedge clk);
        resultsrcM = 1'b0;
        aluresultM = 32'd5;
        ReadDataM  = 32'd2;
        RdM        = 5'd9;
        tick();
        checks++; if (resultW !== 32'd5) begin errors++; $display("FAIL alu_result got %0d want 5", resultW); end
        checks++; if (resultsrcW !== 1'b0) begin errors++; $display("FAIL alu_resultsrc got %0h want 0", resultsrcW); end
        aluresultM = 32'd9;
        resultsrcM = 1'b1;
        #2;
        checks++; if (resultW !== 32'd5) begin errors++; $display("FAIL alu_hold got %0d want 5", resultW); end
        resultsrcM = 1'b0;
        tick();
        checks++; if (resultW !== 32'd9) begin errors++; $display("FAIL alu_next got %0d want 9", resultW); end
    endtask

    task automatic test_x0();
        logic expWe;
`ifdef WB_X0_WRITE_GUARD_EN
        expWe = 1'b0;
`else
        expWe = 1'b1;
`endif
        @(negedge clk);
        regwriteM = 1'b1;
        RdM       = 5'd0;
        tick();
        checks++; if (regwriteW !== expWe) begin errors++; $display("FAIL x0_regwrite got %0h want %0h", regwriteW, expWe); end
        checks++; if (RdW !== 5'd0) begin errors++; $display("FAIL x0_rd got %0d want 0", RdW); end
        @(negedge clk);
        regwriteM = 1'b0;
        RdM       = 5'd31;
        tick();
        checks++; if (regwriteW !== 1'b0) begin errors++; $display("FAIL nowrite_regwrite got %0h want 0", regwriteW); end
        checks++; if (RdW !== 5'd31) begin errors++; $display("FAIL nowrite_rd got %0d want 31", RdW); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        regwriteM  = 1'b1;
        RdM        = 5'd12;
        resultsrcM = 1'b0;
        aluresultM = 32'hFFFF_FFFF;
        tick();
        checks++; if (resultW !== 32'hFFFF_FFFF) begin errors++; $display("FAIL pre_rst_result got %08h want ffffffff", resultW); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (resultW !== 32'h0) begin errors++; $display("FAIL async_rst_result got %08h want 0", resultW); end
        checks++; if (regwriteW !== 1'b0) begin errors++; $display("FAIL async_rst_regwrite got %0h want 0", regwriteW); end
        checks++; if (RdW !== 5'd0) begin errors++; $display("FAIL async_rst_rd got %0d want 0", RdW); end
        #1;
        rst_n = 1'b1;
        tick();
        checks++; if (resultW !== 32'hFFFF_FFFF) begin errors++; $display("FAIL post_rst_result got %08h want ffffffff", resultW); end
        checks++; if (RdW !== 5'd12) begin errors++; $display("FAIL post_rst_rd got %0d want 12", RdW); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        resultsrcM = 1'b1;
        ReadDataM  = 32'h8000_0001;
        aluresultM = 32'h0000_00AA;
        RdM        = 5'd21;
        @(posedge clk);
        #1;
        checks++; if (resultW !== 32'h8000_0001) begin errors++; $display("FAIL b2b0_result got %08h want 80000001", resultW); end
        resultsrcM = 1'b0;
        aluresultM = 32'h7FFF_FFFE;
        RdM        = 5'd22;
        tick();
        checks++; if (resultW !== 32'h7FFF_FFFE) begin errors++; $display("FAIL b2b1_result got %08h want 7ffffffe", resultW); end
        checks++; if (RdW !== 5'd22) begin errors++; $display("FAIL b2b1_rd got %0d want 22", RdW); end
        resultsrcM = 1'b1;
        ReadDataM  = 32'h5A5A_A5A5;
        RdM        = 5'd23;
        tick();
        checks++; if (resultW !== 32'h5A5A_A5A5) begin errors++; $display("FAIL b2b2_result got %08h want 5a5aa5a5", resultW); end
        checks++; if (resultsrcW !== 1'b1) begin errors++; $display("FAIL b2b2_resultsrc got %0h want 1", resultsrcW); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        regwriteM  = 1'b0;
        resultsrcM = 1'b0;
        aluresultM = 32'h0;
        ReadDataM  = 32'h0;
        RdM        = 5'd0;
        test_reset();
        test_load_select();
        test_alu_hold();
        test_x0();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_stage_unit.md
WRITEBACK_STAGE_UNIT -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter DPW, default 32 (rv32i_pkg::DPW), data-path width in bits, SHALL apply to every data port.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous, active-low.
REQ-004 regwriteM  input  1  SHALL be the register-file write enable from the memory stage.
REQ-005 resultsrcM  input  1  SHALL be the result select from the memory stage: 0 = ALU result, 1 = load data.
REQ-006 aluresultM  input  DPW  SHALL be the ALU result from the memory stage.
REQ-007 ReadDataM  input  DPW  SHALL be the data-memory read data from the memory stage.
REQ-008 RdM  input  5  SHALL be the destination register index from the memory stage.
REQ-009 regwriteW  output  1  SHALL be the registered write enable to the register file.
REQ-010 resultsrcW  output  1  SHALL be the registered result select.
REQ-011 resultW  output  DPW  SHALL be the selected writeback data.
REQ-012 RdW  output  5  SHALL be the registered destination register index.

Function
REQ-013 On each rising clk edge with rst_n high, the block SHALL capture regwriteM, resultsrcM, aluresultM, ReadDataM and RdM into internal W-stage registers (MEM/WB pipeline register).
REQ-014 regwriteW, resultsrcW and RdW SHALL be driven directly from their W-stage registers, giving 1-cycle latency from M inputs.
REQ-015 resultW SHALL be combinational from registered values only: the registered ReadData when the registered resultsrc is 1, else the registered aluresult.
REQ-016 resultW SHALL NOT depend combinationally on any M-stage input; input changes between edges SHALL not affect outputs.
REQ-017 All DPW bits SHALL pass unmodified; no sign or zero extension, truncation or arithmetic.
REQ-018 X/unknown inputs SHALL propagate only through the registers they feed; no other state SHALL exist.
REQ-019 There SHALL be no stall, flush or handshake; every edge loads new values.

Reset
REQ-020 While rst_n is low, all W-stage registers SHALL be cleared asynchronously: regwriteW=0, resultsrcW=0, RdW=0, resultW=0.
REQ-021 An rst_n assertion mid-operation SHALL clear the outputs immediately, without waiting for a clock edge.
REQ-022 On rst_n deassertion, the first rising edge with rst_n high SHALL load M inputs normally.

Configuration
REQ-023 Macro WB_X0_WRITE_GUARD_EN: when defined, the registered write enable SHALL be loaded with regwriteM AND (RdM != 0), so regwriteW is never 1 while RdW = 0.
REQ-024 When WB_X0_WRITE_GUARD_EN is undefined, regwriteW SHALL be the registered regwriteM unconditionally, including when RdM = 0.
REQ-025 The macro SHALL affect only regwriteW; RdW, resultsrcW and resultW SHALL be identical in both builds.

Verification
REQ-026 rst_n=0 with random M inputs and clock running -> regwriteW=0, resultsrcW=0, RdW=0, resultW=0; after rst_n=1 the next edge loads the inputs.
REQ-027 resultsrcM=1, aluresultM=5, ReadDataM=2, regwriteM=1, RdM=7, then one edge -> resultW=2, resultsrcW=1, regwriteW=1, RdW=7.
REQ-028 resultsrcM=0, aluresultM=5, ReadDataM=2, then one edge -> resultW=5; changing aluresultM to 9 between edges -> resultW stays 5 until the next edge.
REQ-029 regwriteM=1, RdM=0, then one edge -> regwriteW=0 with WB_X0_WRITE_GUARD_EN defined, regwriteW=1 without; RdW=0 in both builds.
REQ-030 Inputs hold aluresultM=32'hFFFF_FFFF, resultsrcM=0, then rst_n pulses low between edges -> resultW=0 immediately, and resultW=32'hFFFF_FFFF on the first edge after release.
